// File: rtl/tank_ctrl_conditioner.sv
// ---------------------------------------------------------------------------
// tank_ctrl_conditioner : joystick-to-tank-lever conditioner with debounce and coin pulser
// Rev 1.0 -- optional autofire behind macro CTRL_AUTOFIRE_EN
// ---------------------------------------------------------------------------
`default_nettype none

module tank_ctrl_conditioner #(
  parameter int DEB_CYCLES   = 12000,
  parameter int COIN_PULSE   = 600000,
  parameter int COIN_HOLDOFF = 1200000
`ifdef CTRL_AUTOFIRE_EN
  , parameter int AF_PERIOD  = 1200000
`endif
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
`ifdef CTRL_AUTOFIRE_EN
  input  logic        autofire,
`endif
  output logic        joyw_fw_n,
  output logic        joyw_bk_n,
  output logic        joyx_fw_n,
  output logic        joyx_bk_n,
  output logic        joyy_fw_n,
  output logic        joyy_bk_n,
  output logic        joyz_fw_n,
  output logic        joyz_bk_n,
  output logic        fire_a,
  output logic        fire_b,
  output logic        start1_n,
  output logic        start2_n,
  output logic        coin1_n,
  output logic        coin2_n
);

  localparam int MAX_A = (DEB_CYCLES > COIN_PULSE) ? DEB_CYCLES : COIN_PULSE;
  localparam int MAX_B = (MAX_A > COIN_HOLDOFF) ? MAX_A : COIN_HOLDOFF;
`ifdef CTRL_AUTOFIRE_EN
  localparam int MAX_P = (MAX_B > AF_PERIOD) ? MAX_B : AF_PERIOD;
`else
  localparam int MAX_P = MAX_B;
`endif
  localparam int CW = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(COIN_HOLDOFF - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // Bit map: [4:0] P1 {fire,U,D,L,R}, [9:5] P2 same, [10] start1, [11] start2, [12] coin
  logic [12:0] raw;
  logic [12:0] sync1_q, sync2_q;
  logic [12:0] stable;
  logic        unused_hi;

  assign raw = {joy1[7] | joy2[7], joy1[6] | joy2[6], joy1[5] | joy2[5], joy2[4:0], joy1[4:0]};
  assign unused_hi = ^{joy1[15:8], joy2[15:8]};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 13; i++) begin : g_deb
    logic [CW-1:0] cnt_q;
    logic          stab_q;
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        cnt_q  <= '0;
        stab_q <= 1'b0;
      end else if (sync2_q[i] == stab_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_LAST) begin
        stab_q <= sync2_q[i];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
    assign stable[i] = stab_q;
  end

  // {U,D,L,R} -> {W/Y fwd, W/Y back, X/Z fwd, X/Z back}
  function automatic logic [3:0] lever_decode(input logic [3:0] udlr);
    logic [3:0] lev;
    case (udlr)
      4'b1010: lev = 4'b0010;
      4'b1000: lev = 4'b1010;
      4'b1001: lev = 4'b1000;
      4'b0001: lev = 4'b1001;
      4'b0101: lev = 4'b0100;
      4'b0100: lev = 4'b0101;
      4'b0110: lev = 4'b0001;
      4'b0010: lev = 4'b0110;
      default: lev = 4'b0000;
    endcase
    return lev;
  endfunction

  logic [3:0] lev1_q, lev2_q;
  logic [1:0] start_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lev1_q  <= '0;
      lev2_q  <= '0;
      start_q <= '0;
    end else begin
      lev1_q  <= lever_decode(stable[3:0]);
      lev2_q  <= lever_decode(stable[8:5]);
      start_q <= stable[11:10];
    end
  end

  logic [1:0] fire_out;

  for (genvar p = 0; p < 2; p++) begin : g_fire
    logic fire_q;
`ifdef CTRL_AUTOFIRE_EN
    localparam logic [CW-1:0] AF_LAST = CW'(AF_PERIOD - 1);
    logic [CW-1:0] af_cnt_q;
    logic          af_held_q;
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        fire_q    <= 1'b0;
        af_cnt_q  <= '0;
        af_held_q <= 1'b0;
      end else if (!autofire || !stable[p*5+4]) begin
        fire_q    <= stable[p*5+4] & ~autofire;
        af_cnt_q  <= '0;
        af_held_q <= 1'b0;
      end else if (!af_held_q) begin
        fire_q    <= 1'b1;
        af_cnt_q  <= '0;
        af_held_q <= 1'b1;
      end else if (af_cnt_q == AF_LAST) begin
        fire_q   <= ~fire_q;
        af_cnt_q <= '0;
      end else begin
        af_cnt_q <= af_cnt_q + CW'(1);
      end
    end
`else
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) fire_q <= 1'b0;
      else       fire_q <= stable[p*5+4];
    end
`endif
    assign fire_out[p] = fire_q;
  end

  // Coin pulser: edge-triggered, edges during the pulse and holdoff are discarded
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] coin_cnt_q, coin_cnt_d;
  logic          coin_prev_q;

  always_comb begin
    state_d    = state_q;
    coin_cnt_d = coin_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (stable[12] && !coin_prev_q) begin
          state_d    = S_PULSE;
          coin_cnt_d = '0;
        end
      end
      S_PULSE: begin
        if (coin_cnt_q == PULSE_LAST) begin
          state_d    = S_HOLD;
          coin_cnt_d = '0;
        end else begin
          coin_cnt_d = coin_cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (coin_cnt_q == HOLD_LAST) begin
          state_d    = S_IDLE;
          coin_cnt_d = '0;
        end else begin
          coin_cnt_d = coin_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        coin_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      coin_cnt_q  <= '0;
      coin_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      coin_cnt_q  <= coin_cnt_d;
      coin_prev_q <= stable[12];
    end
  end

  assign joyw_fw_n = ~lev1_q[3];
  assign joyw_bk_n = ~lev1_q[2];
  assign joyx_fw_n = ~lev1_q[1];
  assign joyx_bk_n = ~lev1_q[0];
  assign joyy_fw_n = ~lev2_q[3];
  assign joyy_bk_n = ~lev2_q[2];
  assign joyz_fw_n = ~lev2_q[1];
  assign joyz_bk_n = ~lev2_q[0];
  assign fire_a    = fire_out[0];
  assign fire_b    = fire_out[1];
  assign start1_n  = ~start_q[0];
  assign start2_n  = ~start_q[1];
  assign coin1_n   = (state_q != S_PULSE);
  assign coin2_n   = (state_q != S_PULSE);

endmodule

`default_nettype wire

// File: tb/tb_tank_ctrl_conditioner.sv
// ---------------------------------------------------------------------------
// tb_tank_ctrl_conditioner : directed + randomized bench with an event-time reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tank_ctrl_conditioner;

  localparam int DEB = 4;
  localparam int P   = 8;
  localparam int H   = 16;
  localparam logic [13:0] RST_OUT = 14'b11111111_00_11_11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] joy1 = '0;
  logic [15:0] joy2 = '0;
  logic joyw_fw_n, joyw_bk_n, joyx_fw_n, joyx_bk_n;
  logic joyy_fw_n, joyy_bk_n, joyz_fw_n, joyz_bk_n;
  logic fire_a, fire_b, start1_n, start2_n, coin1_n, coin2_n;

  always #5 clk = ~clk;

  tank_ctrl_conditioner #(
    .DEB_CYCLES  (DEB),
    .COIN_PULSE  (P),
    .COIN_HOLDOFF(H)
  ) dut (
    .clk_sys  (clk),
    .reset    (rst),
    .joy1     (joy1),
    .joy2     (joy2),
`ifdef CTRL_AUTOFIRE_EN
    .autofire (1'b0),
`endif
    .joyw_fw_n(joyw_fw_n),
    .joyw_bk_n(joyw_bk_n),
    .joyx_fw_n(joyx_fw_n),
    .joyx_bk_n(joyx_bk_n),
    .joyy_fw_n(joyy_fw_n),
    .joyy_bk_n(joyy_bk_n),
    .joyz_fw_n(joyz_fw_n),
    .joyz_bk_n(joyz_bk_n),
    .fire_a   (fire_a),
    .fire_b   (fire_b),
    .start1_n (start1_n),
    .start2_n (start2_n),
    .coin1_n  (coin1_n),
    .coin2_n  (coin2_n)
  );

  logic [13:0] outv;
  assign outv = {joyw_fw_n, joyw_bk_n, joyx_fw_n, joyx_bk_n,
                 joyy_fw_n, joyy_bk_n, joyz_fw_n, joyz_bk_n,
                 fire_a, fire_b, start1_n, start2_n, coin1_n, coin2_n};

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Tread table straight from the control mapping: {U,D,L,R} -> {Wfw,Wbk,Xfw,Xbk}
  function automatic logic [3:0] lev(input logic [3:0] k);
    case (k)
      4'b1010: return 4'b0010;
      4'b1000: return 4'b1010;
      4'b1001: return 4'b1000;
      4'b0001: return 4'b1001;
      4'b0101: return 4'b0100;
      4'b0100: return 4'b0101;
      4'b0110: return 4'b0001;
      4'b0010: return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  // Reference model: debounce as "run length of the 2-cycle-delayed input",
  // coin as absolute pulse start time plus a ready-again time.
  longint      cyc = 0;
  logic [12:0] s1m = '0, s2m = '0, stm = '0, runv = '0;
  int          runl [13];
  logic        prevc = 1'b0;
  logic        pvalid = 1'b0;
  longint      pstart = 0;
  longint      ready = 0;
  logic [13:0] exp_out = RST_OUT;

  task automatic model_step(input logic r, input logic [12:0] raw);
    logic [12:0] old_st;
    logic        coin_low;
    if (r) begin
      s1m = '0; s2m = '0; stm = '0; runv = '0;
      for (int b = 0; b < 13; b++) runl[b] = 0;
      prevc = 1'b0; pvalid = 1'b0; ready = 0;
      exp_out = RST_OUT;
    end else begin
      old_st = stm;
      for (int b = 0; b < 13; b++) begin
        if (s2m[b] == runv[b]) runl[b]++;
        else begin
          runv[b] = s2m[b];
          runl[b] = 1;
        end
        if (s2m[b] != old_st[b] && runl[b] >= DEB) stm[b] = s2m[b];
      end
      if (old_st[12] && !prevc && cyc >= ready) begin
        pstart = cyc;
        pvalid = 1'b1;
        ready  = cyc + P + H + 1;
      end
      prevc    = old_st[12];
      coin_low = pvalid && (cyc - pstart < P);
      exp_out  = {~lev(old_st[3:0]), ~lev(old_st[8:5]), old_st[4], old_st[9],
                  ~old_st[10], ~old_st[11], ~coin_low, ~coin_low};
      s2m = s1m;
      s1m = raw;
    end
    cyc++;
  endtask

  initial begin
    for (int b = 0; b < 13; b++) runl[b] = 0;
    forever begin
      @(posedge clk);
      #1;
      model_step(rst, {joy1[7] | joy2[7], joy1[6] | joy2[6], joy1[5] | joy2[5], joy2[4:0], joy1[4:0]});
      check("model", {18'd0, outv}, {18'd0, exp_out});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int lowcnt;
  int falls;
  logic prev_coin;
  bit   seen;

  task automatic count_coin(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("coin_pair", {31'd0, coin1_n}, {31'd0, coin2_n});
      if (!coin1_n) lowcnt++;
      if (prev_coin && !coin1_n) falls++;
      prev_coin = coin1_n;
    end
  endtask

  initial begin
    rst = 1'b1;
    cycles(3);
    check("reset_state", {18'd0, outv}, {18'd0, RST_OUT});
    rst = 1'b0;
    cycles(5);

    // Up: both treads forward after exactly DEB+3 edges
    joy1[3] = 1'b1;
    cycles(6);
    check("up_edge6", {28'd0, outv[13:10]}, 32'hF);
    cycles(1);
    check("up_edge7", {28'd0, outv[13:10]}, 32'h5);
    check("up_others", {22'd0, outv[9:0]}, {22'd0, 10'b1111001111});
    joy1 = 16'h000A;
    cycles(10);
    check("up_left", {28'd0, outv[13:10]}, 32'hD);
    joy1 = 16'h000C;
    cycles(10);
    check("up_down", {28'd0, outv[13:10]}, 32'hF);
    joy1 = '0;
    cycles(10);

    // Glitch vs hold on player 2 right
    joy2[0] = 1'b1;
    cycles(3);
    joy2[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      check("glitch3_p2", {28'd0, outv[9:6]}, 32'hF);
    end
    joy2[0] = 1'b1;
    cycles(4);
    joy2[0] = 1'b0;
    cycles(2);
    check("hold4_edge6", {28'd0, outv[9:6]}, 32'hF);
    cycles(1);
    check("hold4_edge7", {28'd0, outv[9:6]}, 32'h6);
    cycles(10);

    // Coin held 100 cycles: one pulse of exactly P
    lowcnt = 0; falls = 0; prev_coin = 1'b1;
    joy1[7] = 1'b1;
    count_coin(100);
    check("coin_held_width", lowcnt, P);
    check("coin_held_pulses", falls, 1);
    joy1[7] = 1'b0;
    cycles(20);

    // Re-press during holdoff is ignored
    lowcnt = 0; falls = 0; prev_coin = 1'b1;
    joy1[7] = 1'b1;
    count_coin(6);
    joy1[7] = 1'b0;
    count_coin(14);
    joy1[7] = 1'b1;
    count_coin(6);
    joy1[7] = 1'b0;
    count_coin(54);
    check("coin_holdoff_width", lowcnt, P);
    check("coin_holdoff_pulses", falls, 1);

    // Re-press after returning to idle gives a second pulse
    lowcnt = 0; falls = 0;
    joy1[7] = 1'b1;
    count_coin(10);
    joy1[7] = 1'b0;
    count_coin(40);
    check("coin_second_width", lowcnt, P);
    check("coin_second_pulses", falls, 1);

    // Both starts together
    joy1[5] = 1'b1;
    joy2[6] = 1'b1;
    cycles(6);
    check("start_edge6", {30'd0, outv[3:2]}, 32'h3);
    cycles(1);
    check("start_edge7", {30'd0, outv[3:2]}, 32'h0);
    joy1[5] = 1'b0;
    joy2[6] = 1'b0;
    cycles(10);
    check("start_release", {30'd0, outv[3:2]}, 32'h3);

    // Asynchronous reset in the middle of a coin pulse
    joy1[3] = 1'b1;
    joy1[7] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycles(1);
      if (!coin1_n) seen = 1'b1;
    end
    check("coin_seen_before_reset", {31'd0, seen}, 32'd1);
    cycles(2);
    rst = 1'b1;
    #1;
    check("reset_async", {18'd0, outv}, {18'd0, RST_OUT});
    cycles(3);
    check("reset_held", {18'd0, outv}, {18'd0, RST_OUT});
    rst = 1'b0;
    cycles(3);
    check("reset_recover", {18'd0, outv}, {18'd0, RST_OUT});
    joy1 = '0;
    cycles(40);

    // Randomized segments, with the occasional reset
    for (int seg = 0; seg < 600; seg++) begin
      joy1 = 16'($urandom);
      joy2 = 16'($urandom);
      joy1[7] = ($urandom_range(0, 5) == 0);
      joy2[7] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      cycles($urandom_range(1, 8));
      rst = 1'b0;
    end
    joy1 = '0;
    joy2 = '0;
    cycles(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
